// File: rtl/croc_pad_in_cond_if.sv
// Pad-side GPIO bundle for croc_pad_in_cond: raw pad levels, filter
// configuration and the conditioned level / edge-pulse outputs.
interface croc_pad_in_cond_if #(
    parameter int unsigned GpioCount  = 32,
    parameter int unsigned FilterCntW = 4,
    parameter int unsigned PrescalerW = 8
);
    logic [GpioCount-1:0]  pad_gpio_i;
    logic [GpioCount-1:0]  filter_en_i;
    logic [FilterCntW-1:0] filter_len_i;
    logic [PrescalerW-1:0] prescale_i;
    logic [GpioCount-1:0]  gpio_o;
    logic [GpioCount-1:0]  rise_o;
    logic [GpioCount-1:0]  fall_o;

    // Pad ring / configuration side
    modport master (
        output pad_gpio_i, filter_en_i, filter_len_i, prescale_i,
        input  gpio_o, rise_o, fall_o
    );

    // Conditioning block side
    modport slave (
        input  pad_gpio_i, filter_en_i, filter_len_i, prescale_i,
        output gpio_o, rise_o, fall_o
    );
endinterface

// File: rtl/croc_pad_in_cond.sv
// GPIO input conditioner: per-pin 2-flop synchroniser, optional prescaled
// stability filter, and registered-level rise/fall pulse generation.
// All state lives in the clk_i domain; only the first sync stage sees pads.
module croc_pad_in_cond #(
    parameter int unsigned GpioCount  = 32,
    parameter int unsigned FilterCntW = 4,
    parameter int unsigned PrescalerW = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    croc_pad_in_cond_if.slave  io
);

    logic [GpioCount-1:0]  sync1_q;
    logic [GpioCount-1:0]  sync2_q;
    logic [PrescalerW-1:0] pre_q, pre_d;
    logic                  tick;
    logic [GpioCount-1:0]  gpio_q, gpio_d;
    logic [GpioCount-1:0]  prev_q;
    logic [FilterCntW-1:0] fcnt_q [GpioCount];
    logic [FilterCntW-1:0] fcnt_d [GpioCount];

    // Two-stage synchroniser for the asynchronous pad levels
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= io.pad_gpio_i;
            sync2_q <= sync1_q;
        end
    end

    // Shared sample-tick prescaler; >= compare makes a lowered prescale_i wrap at once
    always_comb begin
        tick  = (pre_q >= io.prescale_i);
        pre_d = tick ? '0 : pre_q + 1'b1;
    end

    // Per-pin stability filter / bypass
    always_comb begin
        gpio_d = gpio_q;
        fcnt_d = fcnt_q;
        for (int unsigned i = 0; i < GpioCount; i++) begin
            if (!io.filter_en_i[i]) begin
                gpio_d[i] = sync2_q[i];
                fcnt_d[i] = '0;
            end else if (sync2_q[i] == gpio_q[i]) begin
                fcnt_d[i] = '0;
            end else if (tick) begin
                if (fcnt_q[i] >= io.filter_len_i) begin
                    gpio_d[i] = sync2_q[i];
                    fcnt_d[i] = '0;
                end else if (fcnt_q[i] != '1) begin
                    fcnt_d[i] = fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Filter state, conditioned level and previous level for edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pre_q  <= '0;
            gpio_q <= '0;
            prev_q <= '0;
            fcnt_q <= '{default: '0};
        end else begin
            pre_q  <= pre_d;
            gpio_q <= gpio_d;
            prev_q <= gpio_q;
            fcnt_q <= fcnt_d;
        end
    end

    assign io.gpio_o = gpio_q;
    assign io.rise_o = gpio_q & ~prev_q;
    assign io.fall_o = ~gpio_q & prev_q;

endmodule
